// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encoding, the iteration-step mode and per-op signedness helpers.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } mdState_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } stepMode_e;

  // Every divide/remainder op has funct3[2] set.
  function automatic logic isDivide(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic signedA(input logic [2:0] funct3);
    case (funct3)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic signedB(input logic [2:0] funct3);
    case (funct3)
      MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer.
// Multiply mode: accumulator plus (already gated, already shifted) multiplicand.
// Divide mode: accumulator holds {remainder, dividend/quotient}; shift left one,
// trial-subtract the divisor from the widened remainder and restore on borrow.
// In divide mode the new quotient bit is returned separately and acc_o[0] is 0.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  stepMode_e         mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] operand_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0]   remShift;
  logic [XLEN+1:0] trial;

  // Single multiply-add or restoring-divide step.
  always_comb begin
    acc_o    = '0;
    qbit_o   = 1'b0;
    remShift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    trial    = {1'b0, remShift} - {2'b00, operand_i[XLEN-1:0]};
    if (mode_i == STEP_MUL) begin
      acc_o = acc_i + operand_i;
    end else begin
      qbit_o = ~trial[XLEN+1];
      acc_o  = {(qbit_o ? trial[XLEN-1:0] : remShift[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
// IDLE -> PREP -> CALC (XLEN steps) -> FIXUP -> DONE -> IDLE, with divide-by-zero
// and signed overflow resolved straight from PREP to DONE.
// Optional feature macro: MULDIV_EARLY_OUT_EN lets multiplies leave CALC as soon as
// the remaining multiplier bits are all zero (divide latency is unchanged).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_Funct3,
  input  logic [XLEN-1:0] i_OpA,
  input  logic [XLEN-1:0] i_OpB,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_Result,
  output logic            o_busy
);

  localparam logic [5:0]      LAST_COUNT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  mdState_e          state_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   opA_q;
  logic [XLEN-1:0]   opB_q;
  logic              negResult_q;
  logic              negRem_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [5:0]        count_q;
  logic              valid_q;
  logic              ready_q;
  logic              busy_q;
  logic [XLEN-1:0]   result_q;

  logic              signA_d;
  logic              signB_d;
  logic [XLEN-1:0]   magA_d;
  logic [XLEN-1:0]   magB_d;
  logic              divZero_d;
  logic              divOvf_d;
  logic [XLEN-1:0]   special_d;
  logic [2*XLEN-1:0] stepOperand_d;
  stepMode_e         stepMode_d;
  logic [2*XLEN-1:0] stepAcc;
  logic              stepQbit;
  logic [2*XLEN-1:0] product_d;
  logic [XLEN-1:0]   quotient_d;
  logic [XLEN-1:0]   remainder_d;
  logic [XLEN-1:0]   fixupResult_d;
  logic              prepSkip_d;
  logic              calcSkip_d;

  // Operand signs, magnitudes and the divide special cases, all taken from the latched request.
  always_comb begin
    signA_d   = signedA(funct3_q) & opA_q[XLEN-1];
    signB_d   = signedB(funct3_q) & opB_q[XLEN-1];
    magA_d    = signA_d ? (~opA_q + 1'b1) : opA_q;
    magB_d    = signB_d ? (~opB_q + 1'b1) : opB_q;
    divZero_d = isDivide(funct3_q) && (opB_q == '0);
    divOvf_d  = ((funct3_q == MD_DIV) || (funct3_q == MD_REM)) &&
                (opA_q == MOST_NEG) && (opB_q == '1);
    special_d = '0;
    if (divZero_d) begin
      special_d = funct3_q[1] ? opA_q : '1;
    end else if (divOvf_d) begin
      special_d = funct3_q[1] ? '0 : MOST_NEG;
    end
  end

  // Feed the step: divisor for divides, multiplicand gated by the current multiplier bit otherwise.
  always_comb begin
    stepMode_d    = isDivide(funct3_q) ? STEP_DIV : STEP_MUL;
    stepOperand_d = '0;
    if (isDivide(funct3_q) || mplier_q[0]) begin
      stepOperand_d = mcand_q;
    end
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .mode_i    (stepMode_d),
    .acc_i     (acc_q),
    .operand_i (stepOperand_d),
    .acc_o     (stepAcc),
    .qbit_o    (stepQbit)
  );

  // Sign correction and word selection applied in FIXUP.
  always_comb begin
    product_d     = negResult_q ? (~acc_q + 1'b1) : acc_q;
    quotient_d    = negResult_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    remainder_d   = negRem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    fixupResult_d = '0;
    case (funct3_q)
      MD_MUL:                       fixupResult_d = product_d[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixupResult_d = product_d[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fixupResult_d = quotient_d;
      default:                      fixupResult_d = remainder_d;
    endcase
  end

  // Early exit from multiply once no multiplier bits remain to be consumed.
`ifdef MULDIV_EARLY_OUT_EN
  assign prepSkip_d = !isDivide(funct3_q) && (magB_d == '0);
  assign calcSkip_d = !isDivide(funct3_q) && ((mplier_q >> 1) == '0);
`else
  assign prepSkip_d = 1'b0;
  assign calcSkip_d = 1'b0;
`endif

  // Sequencer FSM with registered handshake outputs; reset beats flush, flush beats everything else.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      funct3_q    <= MD_MUL;
      opA_q       <= '0;
      opB_q       <= '0;
      negResult_q <= 1'b0;
      negRem_q    <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else if (i_flush) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            funct3_q <= i_Funct3;
            opA_q    <= i_OpA;
            opB_q    <= i_OpB;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_PREP;
          end
        end
        ST_PREP: begin
          negResult_q <= signA_d ^ signB_d;
          negRem_q    <= signA_d;
          count_q     <= '0;
          if (divZero_d || divOvf_d) begin
            result_q <= special_d;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            if (isDivide(funct3_q)) begin
              acc_q   <= {{XLEN{1'b0}}, magA_d};
              mcand_q <= {{XLEN{1'b0}}, magB_d};
            end else begin
              acc_q    <= '0;
              mcand_q  <= {{XLEN{1'b0}}, magA_d};
              mplier_q <= magB_d;
            end
            state_q <= prepSkip_d ? ST_FIXUP : ST_CALC;
          end
        end
        ST_CALC: begin
          if (isDivide(funct3_q)) begin
            acc_q <= {stepAcc[2*XLEN-1:1], stepQbit};
          end else begin
            acc_q    <= stepAcc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
          count_q <= count_q + 6'd1;
          if ((count_q == LAST_COUNT) || calcSkip_d) begin
            state_q <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          result_q <= fixupResult_d;
          valid_q  <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus randomized
// operations compared against a plain 64-bit arithmetic reference model, with
// latency, backpressure, flush and mid-operation reset checks.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rstN;
  logic        iValid;
  logic        oReady;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        oValid;
  logic        iReady;
  logic [31:0] result;
  logic        busy;

  int vectorCount = 0;
  int missCount   = 0;

  muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .i_valid  (iValid),
    .o_ready  (oReady),
    .i_Funct3 (funct3),
    .i_OpA    (opA),
    .i_OpB    (opB),
    .i_flush  (flush),
    .o_valid  (oValid),
    .i_ready  (iReady),
    .o_Result (result),
    .o_busy   (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Architectural result of an RV32M op, computed with 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Number of rising edges, counting the accepting edge as the first, until o_valid is seen.
  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int bits;
    if (f[2]) begin
      if (b == 32'd0) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
    end
    mag  = (f == 3'd1 && b[31]) ? (~b + 32'd1) : b;
    bits = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return bits + 3;
`else
    return (bits >= 0) ? 35 : 35;
`endif
  endfunction

  // Issue one op, check latency, result, backpressure hold, and the release handshake.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int holdCycles);
    logic [31:0] expResult;
    int expLatency;
    int edges;
    expResult  = refModel(f, a, b);
    expLatency = refLatency(f, a, b);
    @(negedge clk);
    checkOutput("readyIdle", {31'b0, oReady}, 32'd1);
    iValid = 1'b1;
    funct3 = f;
    opA    = a;
    opB    = b;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    edges  = 1;
    checkOutput("busyAfterAccept", {31'b0, busy}, 32'd1);
    while (!oValid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput($sformatf("latency f%0d", f), edges, expLatency);
    checkOutput($sformatf("result f%0d a=%08h b=%08h", f, a, b), result, expResult);
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      #1;
      checkOutput("holdValid", {31'b0, oValid}, 32'd1);
      checkOutput("holdResult", result, expResult);
    end
    @(negedge clk);
    iReady = 1'b1;
    if (!oValid) flush = 1'b1;
    @(posedge clk);
    #1;
    iReady = 1'b0;
    flush  = 1'b0;
    checkOutput("readyAfterDone", {31'b0, oReady}, 32'd1);
    checkOutput("validAfterDone", {31'b0, oValid}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic sawValid;
    rstN   = 1'b0;
    iValid = 1'b0;
    funct3 = 3'd0;
    opA    = '0;
    opB    = '0;
    flush  = 1'b0;
    iReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", {31'b0, oValid}, 32'd0);
    checkOutput("resetResult", result, 32'd0);
    checkOutput("resetBusy", {31'b0, busy}, 32'd0);
    checkOutput("resetReady", {31'b0, oReady}, 32'd1);
    @(negedge clk);
    rstN = 1'b1;

    // Directed cases.
    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'd5, 32'd100, 32'd7, 0);
    applyStimulus(3'd7, 32'd100, 32'd7, 0);
    applyStimulus(3'd4, 32'd5, 32'd0, 0);
    applyStimulus(3'd7, 32'd5, 32'd0, 0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd0, 32'h1234_5678, 32'd0, 0);
    applyStimulus(3'd5, 32'hFFFF_FFFF, 32'd1, 5);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), $urandom_range(0, 3));
    end

    // Flush and request on the same idle edge: flush wins.
    @(negedge clk);
    iValid = 1'b1;
    flush  = 1'b1;
    funct3 = 3'd0;
    opA    = 32'd3;
    opB    = 32'd3;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    flush  = 1'b0;
    checkOutput("flushIdleReady", {31'b0, oReady}, 32'd1);
    checkOutput("flushIdleBusy", {31'b0, busy}, 32'd0);

    // Flush in CALC cycle 10: back to idle on the next edge with no result.
    @(negedge clk);
    iValid = 1'b1;
    funct3 = 3'd5;
    opA    = 32'd1000;
    opB    = 32'd3;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    checkOutput("busyBeforeFlush", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushBusy", {31'b0, busy}, 32'd0);
    checkOutput("flushReady", {31'b0, oReady}, 32'd1);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (oValid) sawValid = 1'b1;
    end
    checkOutput("flushNoValid", {31'b0, sawValid}, 32'd0);

    // Reset mid-CALC: all outputs return to reset values.
    applyStimulus(3'd0, 32'd9, 32'd9, 0);
    @(negedge clk);
    iValid = 1'b1;
    funct3 = 3'd1;
    opA    = 32'hDEAD_BEEF;
    opB    = 32'h1234_5678;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midResetValid", {31'b0, oValid}, 32'd0);
    checkOutput("midResetResult", result, 32'd0);
    checkOutput("midResetBusy", {31'b0, busy}, 32'd0);
    checkOutput("midResetReady", {31'b0, oReady}, 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(3'd6, 32'd17, 32'hFFFF_FFFB, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
